instr_fetch_queue: RTL
======================

// Module: instr_fetch_queue
// PURPOSE
//  Fetch stage directly downstream of the instruction-memory read-signal generator.
//  Owns the PC and issues req/gnt reads to instruction memory once imrd_read is high.
//  Buffers returned words with their PCs in an in-order FIFO.
//  Presents them to decode over a valid/ready handshake and handles branch/jump redirects.
// PARAMETERS
//  XLEN      32            address/PC width
//  RESET_PC  32'h0000_0000 PC loaded at reset
//  DEPTH     4             FIFO entries, power of 2, >=2; also max outstanding reads
// PORTS
//  IMRD_clk        in  1     clock, rising edge
//  IMRD_reset_in   in  1     reset, asynchronous, active-low
//  imrd_read       in  1     fetch enable from read-signal generator; no new requests while 0
//  redirect_valid  in  1     one-cycle pulse: restart fetch at redirect_pc
//  redirect_pc     in  XLEN  redirect target; bits [1:0] ignored (forced 0)
//  imem_req        out 1     read request
//  imem_addr       out XLEN  read address (word aligned)
//  imem_gnt        in  1     request accepted this cycle
//  imem_rvalid     in  1     read data valid; in order, >=1 cycle after gnt
//  imem_rdata      in  32    instruction word
//  inst_valid      out 1     FIFO head valid to decode
//  inst_ready      in  1     decode accepts head
//  inst_data       out 32    head instruction
//  inst_pc         out XLEN  head PC
// BEHAVIOUR
//  Reset: pc=RESET_PC, FIFO empty, outstanding=0, discard=0, state=IDLE.
//   All outputs 0 except imem_addr=RESET_PC.
//  States: IDLE (imrd_read=0), FETCH, FLUSH (discard>0 after redirect).
//   IDLE->FETCH when imrd_read=1.
//   FETCH->IDLE when imrd_read=0; outstanding reads still complete and are stored.
//   Any->FLUSH on redirect_valid when discard_next>0, else ->FETCH/IDLE.
//   FLUSH->FETCH/IDLE when discard reaches 0.
//  Credit: imem_req=1 iff state==FETCH && !redirect_valid && (count+outstanding)<DEPTH.
//   imem_addr=pc combinational from the register.
//   imem_req stays high until gnt; address stable while waiting.
//  On imem_req&&imem_gnt: pc<=pc+4 (wraps mod 2^XLEN) and outstanding++.
//  On imem_rvalid: outstanding--.
//   If discard>0: drop the word, discard--.
//   Else: push {imem_rdata, pc_of_request}. The request PC comes from a DEPTH-deep PC
//   shadow or is tracked per entry. Overflow is impossible by credit.
//  Pop on inst_valid&&inst_ready. Push and pop in the same cycle are both honoured.
//   inst_* come from registered FIFO storage; latency gnt->inst_valid = rvalid cycle + 1.
//  redirect_valid (highest priority):
//   - FIFO cleared and pc<=redirect_pc&~3 next cycle.
//   - discard<=outstanding_next, i.e. outstanding including a grant this cycle and
//     excluding an rvalid this cycle.
//   - Any rvalid in the redirect cycle is dropped.
//   - inst_valid=0 the cycle after.
//   - A pop in the same cycle is ignored.
//  Redirect during FLUSH: discard recomputed as above; no double counting.
//  Reset mid-operation: async clear of all state; in-flight responses after reset are
//   not tracked. The memory side must be reset by the same signal.
// CONFIGURATION
//  IFQ_PERF_CNT_EN defined: adds two ports.
//   - perf_stall_cnt out 32: cycles with inst_ready&&!inst_valid&&imrd_read.
//   - perf_flush_cnt out 32: count of redirect_valid pulses.
//   Both saturate at 32'hFFFF_FFFF and reset to 0.
//  IFQ_PERF_CNT_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  T1 Reset: reset low with imrd_read=1 -> imem_req=0, inst_valid=0, imem_addr=0.
//   Release -> req at 0x0, then 0x4, 0x8.
//  T2 Stream: gnt=1 always, rvalid 1 cycle later, inst_ready=1.
//   -> inst_pc 0x0,0x4,0x8,... consecutive, inst_data matches memory, no gaps after fill.
//  T3 Full: inst_ready=0 with DEPTH=4 -> exactly 4 grants, then imem_req=0.
//   One pop -> exactly one new request.
//  T4 Redirect: redirect to 0x103 with 2 reads outstanding.
//   -> 2 responses dropped, next inst_pc=0x100, FIFO flushed, no stale word delivered.
//  T5 Corners:
//   - redirect in same cycle as gnt and rvalid -> discard count correct.
//   - pc 0xFFFF_FFFC+4 wraps to 0x0.
//   - imrd_read drop mid-stream -> no new req, outstanding words still enqueued.
//  T6 IFQ_PERF_CNT_EN: 3 redirects -> perf_flush_cnt=3.
//   10 starved cycles -> perf_stall_cnt=10.

Source files
------------

// File: rtl/instr_fetch_queue_if.sv
// Fetch-side bus bundle: instruction-memory req/gnt/rvalid channel plus the
// valid/ready channel toward decode. master = fetch queue, slave = memory/decode side.
interface instr_fetch_queue_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     inst_data;
  logic [XLEN-1:0] inst_pc;

  modport master (
    output imem_req, imem_addr, inst_valid, inst_data, inst_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_data, inst_pc,
    output imem_gnt, imem_rvalid, imem_rdata, inst_ready
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: PC owner, credit-limited req/gnt fetcher and in-order FIFO to decode.
// Optional macro IFQ_PERF_CNT_EN adds saturating stall/flush performance counters.
module instr_fetch_queue #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 4
) (
  input  logic                IMRD_clk,
  input  logic                IMRD_reset_in,
  input  logic                imrd_read,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_pc,
  instr_fetch_queue_if.master bus
`ifdef IFQ_PERF_CNT_EN
  ,
  output logic [31:0]         perf_stall_cnt,
  output logic [31:0]         perf_flush_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;

  state_t          state;
  state_t          resume_state;
  logic [XLEN-1:0] pc;
  logic [31:0]     data_q   [DEPTH];
  logic [XLEN-1:0] pc_q     [DEPTH];
  logic [XLEN-1:0] shadow_q [DEPTH];
  logic [PW:0]     wr_ptr, rd_ptr, sh_wr, sh_rd;
  logic [PW:0]     count, outstanding, outstanding_nxt, discard, discard_nxt;
  logic [PW+1:0]   credit_used;
  logic            grant, rsp, push, pop;

  // Outstanding reads are the occupancy of the request-PC shadow, so they can never drift.
  assign count        = wr_ptr - rd_ptr;
  assign outstanding  = sh_wr - sh_rd;
  assign credit_used  = {1'b0, count} + {1'b0, outstanding};
  assign resume_state = imrd_read ? FETCH : IDLE;

  assign bus.imem_req  = (state == FETCH) && !redirect_valid
                         && (credit_used < (PW+2)'(DEPTH));
  assign bus.imem_addr = pc;

  assign grant = bus.imem_req && bus.imem_gnt;
  assign rsp   = bus.imem_rvalid && (outstanding != '0);
  assign push  = rsp && (discard == '0) && !redirect_valid;
  assign pop   = bus.inst_valid && bus.inst_ready && !redirect_valid;

  assign outstanding_nxt = outstanding + {{PW{1'b0}}, grant} - {{PW{1'b0}}, rsp};
  assign discard_nxt     = redirect_valid            ? outstanding_nxt :
                           (rsp && discard != '0)    ? discard - (PW+1)'(1) :
                                                       discard;

  assign bus.inst_valid = (count != '0);
  assign bus.inst_data  = data_q[rd_ptr[PW-1:0]];
  assign bus.inst_pc    = pc_q[rd_ptr[PW-1:0]];

  always_ff @(posedge IMRD_clk or negedge IMRD_reset_in) begin
    if (!IMRD_reset_in) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      discard <= '0;
      sh_wr   <= '0;
      sh_rd   <= '0;
    end else begin
      discard <= discard_nxt;
      if (grant) sh_wr <= sh_wr + (PW+1)'(1);
      if (rsp)   sh_rd <= sh_rd + (PW+1)'(1);
      if (redirect_valid) begin
        pc    <= redirect_pc & ~XLEN'(3);
        state <= (outstanding_nxt != '0) ? FLUSH : resume_state;
      end else begin
        if (grant) pc <= pc + XLEN'(4);
        case (state)
          IDLE, FETCH: state <= resume_state;
          FLUSH:       if (discard_nxt == '0) state <= resume_state;
          default:     state <= IDLE;
        endcase
      end
    end
  end

  // Redirect empties the FIFO by snapping the write pointer back onto the read pointer.
  always_ff @(posedge IMRD_clk or negedge IMRD_reset_in) begin
    if (!IMRD_reset_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i]   <= '0;
        pc_q[i]     <= '0;
        shadow_q[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (grant) shadow_q[sh_wr[PW-1:0]] <= pc;
      if (redirect_valid) begin
        wr_ptr <= rd_ptr;
      end else begin
        if (push) begin
          data_q[wr_ptr[PW-1:0]] <= bus.imem_rdata;
          pc_q[wr_ptr[PW-1:0]]   <= shadow_q[sh_rd[PW-1:0]];
          wr_ptr                 <= wr_ptr + (PW+1)'(1);
        end
        if (pop) rd_ptr <= rd_ptr + (PW+1)'(1);
      end
    end
  end

`ifdef IFQ_PERF_CNT_EN
  always_ff @(posedge IMRD_clk or negedge IMRD_reset_in) begin
    if (!IMRD_reset_in) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (bus.inst_ready && !bus.inst_valid && imrd_read && perf_stall_cnt != '1)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (redirect_valid && perf_flush_cnt != '1)
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule
